avst_rx_to_mfb: RTL and testbench

- RX-side converter between the Ethernet-core AVST receive stream and the single-region user MFB stream.
- Reverses byte order, turns EMPTY/ERROR into EOF_POS and per-frame META (error flag + byte length).
- The AVST side has no backpressure, so a small FIFO absorbs MFB DST_RDY stalls.
- On overflow or protocol violation the frame is truncated: a synthetic EOF word with the error flag set is written, so MFB framing always stays well formed.

---
 rtl/avst_rx_to_mfb_pkg.sv | 51 +++++
 rtl/avst_rx_to_mfb_if.sv | 36 +++
 rtl/avst_rx_to_mfb_fifo.sv | 49 ++++
 rtl/avst_rx_to_mfb.sv | 157 +++++++++++++++
 tb/tb_avst_rx_to_mfb.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/avst_rx_to_mfb_pkg.sv
// Shared configuration, derived widths, FSM state and FIFO word layout for the AVST RX -> MFB converter.
// Single region (REGIONS=1); all widths below follow from the six base parameters.
package avst_rx_to_mfb_pkg;

   localparam int REGION_SIZE = 8;
   localparam int BLOCK_SIZE  = 8;
   localparam int ITEM_WIDTH  = 8;
   localparam int FIFO_DEPTH  = 16;
   localparam int ERR_WIDTH   = 6;
   localparam int LEN_WIDTH   = 16;

   localparam int WB        = REGION_SIZE * BLOCK_SIZE;
   localparam int W         = WB * ITEM_WIDTH;
   localparam int EOF_POS_W = $clog2(WB);
   localparam int SOF_POS_W = (REGION_SIZE > 1) ? $clog2(REGION_SIZE) : 1;
   localparam int PTR_W     = $clog2(FIFO_DEPTH);
   localparam int CNT_W     = PTR_W + 1;
   localparam int META_W    = LEN_WIDTH + 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PASS    = 2'd1,
      ST_DISCARD = 2'd2
   } state_e;

   typedef struct packed {
      logic [W-1:0]         data;
      logic                 sof;
      logic                 eof;
      logic [EOF_POS_W-1:0] eof_pos;
      logic [META_W-1:0]    meta;
   } fifo_word_t;

   // AVST puts the first byte in the top lane, MFB puts item 0 in the bottom lane.
   function automatic logic [W-1:0] item_reverse(input logic [W-1:0] d);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < WB; i++) begin
         r[i*ITEM_WIDTH +: ITEM_WIDTH] = d[(WB-1-i)*ITEM_WIDTH +: ITEM_WIDTH];
      end
      return r;
   endfunction

   function automatic logic [LEN_WIDTH-1:0] len_sat_add(input logic [LEN_WIDTH-1:0] a,
                                                       input logic [LEN_WIDTH-1:0] b);
      logic [LEN_WIDTH:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[LEN_WIDTH] ? '1 : s[LEN_WIDTH-1:0];
   endfunction

endpackage

// File: rtl/avst_rx_to_mfb_if.sv
// AVST receive stream in, single-region MFB stream out; the converter takes the slave view.
// The master view belongs to whatever drives AVST and consumes MFB.
interface avst_rx_to_mfb_if;
   import avst_rx_to_mfb_pkg::*;

   logic [W-1:0]         RX_AVST_DATA;
   logic                 RX_AVST_SOP;
   logic                 RX_AVST_EOP;
   logic [EOF_POS_W-1:0] RX_AVST_EMPTY;
   logic [ERR_WIDTH-1:0] RX_AVST_ERROR;
   logic                 RX_AVST_VALID;

   logic [W-1:0]         TX_MFB_DATA;
   logic [META_W-1:0]    TX_MFB_META;
   logic                 TX_MFB_SOF;
   logic                 TX_MFB_EOF;
   logic [SOF_POS_W-1:0] TX_MFB_SOF_POS;
   logic [EOF_POS_W-1:0] TX_MFB_EOF_POS;
   logic                 TX_MFB_SRC_RDY;
   logic                 TX_MFB_DST_RDY;

   modport master (
      output RX_AVST_DATA, RX_AVST_SOP, RX_AVST_EOP, RX_AVST_EMPTY, RX_AVST_ERROR, RX_AVST_VALID,
      input  TX_MFB_DATA, TX_MFB_META, TX_MFB_SOF, TX_MFB_EOF, TX_MFB_SOF_POS, TX_MFB_EOF_POS,
      input  TX_MFB_SRC_RDY,
      output TX_MFB_DST_RDY
   );

   modport slave (
      input  RX_AVST_DATA, RX_AVST_SOP, RX_AVST_EOP, RX_AVST_EMPTY, RX_AVST_ERROR, RX_AVST_VALID,
      output TX_MFB_DATA, TX_MFB_META, TX_MFB_SOF, TX_MFB_EOF, TX_MFB_SOF_POS, TX_MFB_EOF_POS,
      output TX_MFB_SRC_RDY,
      input  TX_MFB_DST_RDY
   );

endinterface

// File: rtl/avst_rx_to_mfb_fifo.sv
// Register-array FWFT FIFO; a write is visible on rd_dat_o the next cycle, output is zero while empty.
// Backpressure: rd_i is only honoured when not empty; a write when full is accepted only alongside a read.
module avst_rx_to_mfb_fifo
   import avst_rx_to_mfb_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             wr_i,
   input  fifo_word_t       wr_dat_i,
   input  logic             rd_i,
   output fifo_word_t       rd_dat_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] free_cnt_o
);

   fifo_word_t       mem_q [FIFO_DEPTH];
   logic [CNT_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] used;
   logic             do_wr, do_rd;

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   assign used       = wr_ptr_q - rd_ptr_q;
   assign empty_o    = (used == '0);
   assign full_o     = (used == CNT_W'(FIFO_DEPTH));
   assign free_cnt_o = CNT_W'(FIFO_DEPTH) - used;

   assign do_rd = rd_i & ~empty_o;
   assign do_wr = wr_i & (~full_o | do_rd);

   always_ff @(posedge clk_i) begin
      if (do_wr) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_dat_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   assign rd_dat_o = empty_o ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/avst_rx_to_mfb.sv
// AVST RX -> MFB converter: byte reversal, EMPTY/ERROR to EOF_POS/META, 1-cycle latency through a FWFT FIFO.
// AVST cannot be stalled: DST_RDY stalls fill the FIFO, overflow truncates with a synthetic error EOF.
// Optional frame/truncation/drop counters with AVST_RX_TO_MFB_STATS_EN.
module avst_rx_to_mfb
   import avst_rx_to_mfb_pkg::*;
(
   input  logic             CLK,
   input  logic             RESET_N,
   avst_rx_to_mfb_if.slave  avst_mfb
`ifdef AVST_RX_TO_MFB_STATS_EN
   ,
   output logic [31:0]      STAT_FRAMES,
   output logic [31:0]      STAT_TRUNC,
   output logic [31:0]      STAT_DROP
`endif
);

   state_e               state_q, state_d;
   logic [LEN_WIDTH-1:0] len_q, len_d;

   fifo_word_t           wr_word, rd_word;
   logic                 wr_en, rd_en, fifo_full, fifo_empty;
   logic [CNT_W-1:0]     free_cnt, free_eff;
   logic                 room2;

   logic                 frame_done, trunc, drop;
   logic [W-1:0]         swapped;
   logic [LEN_WIDTH-1:0] last_bytes, len_full;
   logic [EOF_POS_W-1:0] last_pos;
   logic                 err;

   assign swapped    = item_reverse(avst_mfb.RX_AVST_DATA);
   assign last_bytes = LEN_WIDTH'(WB) - LEN_WIDTH'(avst_mfb.RX_AVST_EMPTY);
   assign last_pos   = EOF_POS_W'(WB - 1) - avst_mfb.RX_AVST_EMPTY;
   assign err        = |avst_mfb.RX_AVST_ERROR;
   assign len_full   = len_sat_add(len_q, LEN_WIDTH'(WB));

   // A read in this cycle frees a slot before the write lands.
   assign rd_en    = ~fifo_empty & avst_mfb.TX_MFB_DST_RDY;
   assign free_eff = free_cnt + CNT_W'(rd_en);
   assign room2    = (free_eff >= CNT_W'(2));

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      wr_en      = 1'b0;
      wr_word    = '0;
      frame_done = 1'b0;
      trunc      = 1'b0;
      drop       = 1'b0;
      if (avst_mfb.RX_AVST_VALID) begin
         case (state_q)
            ST_IDLE: begin
               if (avst_mfb.RX_AVST_SOP) begin
                  if (room2) begin
                     wr_en        = 1'b1;
                     wr_word.data = swapped;
                     wr_word.sof  = 1'b1;
                     if (avst_mfb.RX_AVST_EOP) begin
                        wr_word.eof     = 1'b1;
                        wr_word.eof_pos = last_pos;
                        wr_word.meta    = {err, last_bytes};
                        frame_done      = 1'b1;
                     end else begin
                        len_d   = LEN_WIDTH'(WB);
                        state_d = ST_PASS;
                     end
                  end else begin
                     drop = 1'b1;
                     if (!avst_mfb.RX_AVST_EOP) state_d = ST_DISCARD;
                  end
               end
            end
            ST_PASS: begin
               if (avst_mfb.RX_AVST_SOP || (!avst_mfb.RX_AVST_EOP && !room2)) begin
                  // Close the open frame with an empty error EOF; the current word is lost.
                  wr_en        = 1'b1;
                  wr_word.eof  = 1'b1;
                  wr_word.meta = {1'b1, len_q};
                  trunc        = 1'b1;
                  state_d      = (avst_mfb.RX_AVST_SOP && avst_mfb.RX_AVST_EOP) ? ST_IDLE : ST_DISCARD;
               end else if (avst_mfb.RX_AVST_EOP) begin
                  wr_en           = 1'b1;
                  wr_word.data    = swapped;
                  wr_word.eof     = 1'b1;
                  wr_word.eof_pos = last_pos;
                  wr_word.meta    = {err, len_sat_add(len_q, last_bytes)};
                  frame_done      = 1'b1;
                  state_d         = ST_IDLE;
               end else begin
                  wr_en        = 1'b1;
                  wr_word.data = swapped;
                  len_d        = len_full;
               end
            end
            ST_DISCARD: begin
               if (avst_mfb.RX_AVST_EOP) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         len_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
      end
   end

   avst_rx_to_mfb_fifo u_fifo (
      .clk_i      (CLK),
      .rst_ni     (RESET_N),
      .wr_i       (wr_en),
      .wr_dat_i   (wr_word),
      .rd_i       (rd_en),
      .rd_dat_o   (rd_word),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .free_cnt_o (free_cnt)
   );

   assign avst_mfb.TX_MFB_DATA    = rd_word.data;
   assign avst_mfb.TX_MFB_META    = rd_word.meta;
   assign avst_mfb.TX_MFB_SOF     = rd_word.sof;
   assign avst_mfb.TX_MFB_EOF     = rd_word.eof;
   assign avst_mfb.TX_MFB_EOF_POS = rd_word.eof_pos;
   assign avst_mfb.TX_MFB_SOF_POS = '0;
   assign avst_mfb.TX_MFB_SRC_RDY = ~fifo_empty;

`ifdef AVST_RX_TO_MFB_STATS_EN
   logic [31:0] frames_q, trunc_q, drop_q;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         frames_q <= '0;
         trunc_q  <= '0;
         drop_q   <= '0;
      end else begin
         if (frame_done) frames_q <= frames_q + 32'd1;
         if (trunc)      trunc_q  <= trunc_q + 32'd1;
         if (drop)       drop_q   <= drop_q + 32'd1;
      end
   end

   assign STAT_FRAMES = frames_q;
   assign STAT_TRUNC  = trunc_q;
   assign STAT_DROP   = drop_q;
`else
   logic unused_stats;
   assign unused_stats = frame_done ^ trunc ^ drop ^ fifo_full;
`endif

endmodule

// File: tb/tb_avst_rx_to_mfb.sv
// Directed bench for avst_rx_to_mfb: reset, single/multi-word frames, overflow truncation,
// SOP-in-frame, throttled back-to-back traffic and mid-frame reset.
module tb_avst_rx_to_mfb;
   import avst_rx_to_mfb_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   avst_rx_to_mfb_if bus_if();

`ifdef AVST_RX_TO_MFB_STATS_EN
   logic [31:0] stat_frames, stat_trunc, stat_drop;
`endif

   avst_rx_to_mfb dut (
      .CLK         (clk),
      .RESET_N     (rst_n),
      .avst_mfb    (bus_if)
`ifdef AVST_RX_TO_MFB_STATS_EN
      ,
      .STAT_FRAMES (stat_frames),
      .STAT_TRUNC  (stat_trunc),
      .STAT_DROP   (stat_drop)
`endif
   );

   always #5 clk = ~clk;

   // AVST lane k (bits 8k+7:8k) carries base+k.
   function automatic logic [W-1:0] pat(input logic [7:0] base);
      logic [W-1:0] v;
      v = '0;
      for (int k = 0; k < WB; k++) v[k*8 +: 8] = base + 8'(k);
      return v;
   endfunction

   // Expected MFB image of pat(base): item i holds the byte from AVST lane 63-i.
   function automatic logic [W-1:0] pat_mfb(input logic [7:0] base);
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < WB; i++) v[i*8 +: 8] = base + 8'(WB - 1 - i);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] d, input logic sop, input logic eop,
                       input logic [5:0] empty, input logic [5:0] errv);
      bus_if.RX_AVST_DATA  = d;
      bus_if.RX_AVST_SOP   = sop;
      bus_if.RX_AVST_EOP   = eop;
      bus_if.RX_AVST_EMPTY = empty;
      bus_if.RX_AVST_ERROR = errv;
      bus_if.RX_AVST_VALID = 1'b1;
      tick();
   endtask

   task automatic idle();
      bus_if.RX_AVST_VALID = 1'b0;
      bus_if.RX_AVST_SOP   = 1'b0;
      bus_if.RX_AVST_EOP   = 1'b0;
      tick();
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_d(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   typedef struct packed {
      logic [W-1:0]  data;
      logic [16:0]   meta;
   } exp_t;

   exp_t        sb[$];
   exp_t        head;
   int          n, eof_cnt, sent, got;
   logic [16:0] last_meta;
   logic [W-1:0] last_data;
   logic [5:0]  last_pos;
   logic        last_eof;

   initial begin
      rst_n = 1'b0;
      bus_if.RX_AVST_DATA   = '0;
      bus_if.RX_AVST_SOP    = 1'b0;
      bus_if.RX_AVST_EOP    = 1'b0;
      bus_if.RX_AVST_EMPTY  = '0;
      bus_if.RX_AVST_ERROR  = '0;
      bus_if.RX_AVST_VALID  = 1'b0;
      bus_if.TX_MFB_DST_RDY = 1'b0;
      tick();
      tick();
      chk("rst_src_rdy", 32'(bus_if.TX_MFB_SRC_RDY), 32'd0);
      chk("rst_sof", 32'(bus_if.TX_MFB_SOF), 32'd0);
      chk("rst_eof", 32'(bus_if.TX_MFB_EOF), 32'd0);
      chk("rst_meta", 32'(bus_if.TX_MFB_META), 32'd0);
      chk("rst_eof_pos", 32'(bus_if.TX_MFB_EOF_POS), 32'd0);
      chk("rst_sof_pos", 32'(bus_if.TX_MFB_SOF_POS), 32'd0);
      chk_d("rst_data", bus_if.TX_MFB_DATA, '0);
      rst_n = 1'b1;
      tick();

      // 1-word frame, EMPTY=4
      bus_if.TX_MFB_DST_RDY = 1'b1;
      send(pat(8'h10), 1'b1, 1'b1, 6'd4, 6'd0);
      chk("t1_src_rdy", 32'(bus_if.TX_MFB_SRC_RDY), 32'd1);
      chk("t1_sof", 32'(bus_if.TX_MFB_SOF), 32'd1);
      chk("t1_eof", 32'(bus_if.TX_MFB_EOF), 32'd1);
      chk("t1_eof_pos", 32'(bus_if.TX_MFB_EOF_POS), 32'd59);
      chk("t1_meta", 32'(bus_if.TX_MFB_META), 32'd60);
      chk_d("t1_data", bus_if.TX_MFB_DATA, pat_mfb(8'h10));
      idle();
      chk("t1_drained", 32'(bus_if.TX_MFB_SRC_RDY), 32'd0);

      // 3-word frame, error on EOP
      send(pat(8'h40), 1'b1, 1'b0, 6'd0, 6'd0);
      chk("t2_w0_sof", 32'(bus_if.TX_MFB_SOF), 32'd1);
      chk("t2_w0_meta", 32'(bus_if.TX_MFB_META), 32'd0);
      chk_d("t2_w0_data", bus_if.TX_MFB_DATA, pat_mfb(8'h40));
      send(pat(8'h80), 1'b0, 1'b0, 6'd0, 6'd0);
      chk("t2_w1_sofeof", 32'({bus_if.TX_MFB_SOF, bus_if.TX_MFB_EOF}), 32'd0);
      chk_d("t2_w1_data", bus_if.TX_MFB_DATA, pat_mfb(8'h80));
      send(pat(8'hC0), 1'b0, 1'b1, 6'd0, 6'h01);
      chk("t2_w2_sofeof", 32'({bus_if.TX_MFB_SOF, bus_if.TX_MFB_EOF}), 32'd1);
      chk("t2_w2_eof_pos", 32'(bus_if.TX_MFB_EOF_POS), 32'd63);
      chk("t2_w2_meta", 32'(bus_if.TX_MFB_META), 32'h000100C0);
      idle();

      // 20-word frame with DST_RDY held low, then a frame arriving into a full FIFO
      bus_if.TX_MFB_DST_RDY = 1'b0;
      for (int k = 0; k < 20; k++) begin
         send(pat(8'(30 + k)), (k == 0), (k == 19), 6'd0, 6'd0);
      end
      send(pat(8'hEE), 1'b1, 1'b1, 6'd0, 6'd0);
      idle();
      chk("t3_held_sof", 32'(bus_if.TX_MFB_SOF), 32'd1);
      chk_d("t3_held_data", bus_if.TX_MFB_DATA, pat_mfb(8'd30));
      bus_if.TX_MFB_DST_RDY = 1'b1;
      n = 0;
      eof_cnt = 0;
      for (int c = 0; c < 40 && bus_if.TX_MFB_SRC_RDY; c++) begin
         if (n == 14) chk_d("t3_w14_data", bus_if.TX_MFB_DATA, pat_mfb(8'd44));
         if (bus_if.TX_MFB_EOF) eof_cnt++;
         last_meta = bus_if.TX_MFB_META;
         last_data = bus_if.TX_MFB_DATA;
         last_pos  = bus_if.TX_MFB_EOF_POS;
         last_eof  = bus_if.TX_MFB_EOF;
         n++;
         tick();
      end
      chk("t3_words", 32'(n), 32'd16);
      chk("t3_eof_count", 32'(eof_cnt), 32'd1);
      chk("t3_last_eof", 32'(last_eof), 32'd1);
      chk("t3_last_meta", 32'(last_meta), 32'h000103C0);
      chk("t3_last_pos", 32'(last_pos), 32'd0);
      chk_d("t3_last_data", last_data, '0);
`ifdef AVST_RX_TO_MFB_STATS_EN
      chk("t3_stat_frames", stat_frames, 32'd2);
      chk("t3_stat_trunc", stat_trunc, 32'd1);
      chk("t3_stat_drop", stat_drop, 32'd1);
`endif

      // SOP inside an open frame, then a SOP during DISCARD, then a clean frame
      send(pat(8'h01), 1'b1, 1'b0, 6'd0, 6'd0);
      chk("t4_w0_sof", 32'(bus_if.TX_MFB_SOF), 32'd1);
      send(pat(8'h02), 1'b0, 1'b0, 6'd0, 6'd0);
      chk_d("t4_w1_data", bus_if.TX_MFB_DATA, pat_mfb(8'h02));
      send(pat(8'h03), 1'b1, 1'b0, 6'd0, 6'd0);
      chk("t4_synth_eof", 32'(bus_if.TX_MFB_EOF), 32'd1);
      chk("t4_synth_meta", 32'(bus_if.TX_MFB_META), 32'h00010080);
      chk_d("t4_synth_data", bus_if.TX_MFB_DATA, '0);
      send(pat(8'h04), 1'b1, 1'b0, 6'd0, 6'd0);
      chk("t4_discard_sop", 32'(bus_if.TX_MFB_SRC_RDY), 32'd0);
      send(pat(8'h05), 1'b0, 1'b1, 6'd0, 6'd0);
      chk("t4_discard_eop", 32'(bus_if.TX_MFB_SRC_RDY), 32'd0);
      send(pat(8'h50), 1'b1, 1'b0, 6'd0, 6'd0);
      chk("t4_clean_sof", 32'(bus_if.TX_MFB_SOF), 32'd1);
      chk_d("t4_clean_w0", bus_if.TX_MFB_DATA, pat_mfb(8'h50));
      send(pat(8'h90), 1'b0, 1'b1, 6'd10, 6'd0);
      chk("t4_clean_eof_pos", 32'(bus_if.TX_MFB_EOF_POS), 32'd53);
      chk("t4_clean_meta", 32'(bus_if.TX_MFB_META), 32'd118);
      idle();

      // back-to-back single-word frames, DST_RDY toggling
      sent = 0;
      got = 0;
      sb.delete();
      for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
         bus_if.TX_MFB_DST_RDY = cyc[0];
         if (sent < 10) begin
            bus_if.RX_AVST_DATA  = pat(8'(sent * 7));
            bus_if.RX_AVST_SOP   = 1'b1;
            bus_if.RX_AVST_EOP   = 1'b1;
            bus_if.RX_AVST_EMPTY = 6'd0;
            bus_if.RX_AVST_ERROR = (sent % 3 == 1) ? 6'h20 : 6'h00;
            bus_if.RX_AVST_VALID = 1'b1;
            sb.push_back('{data: pat_mfb(8'(sent * 7)),
                           meta: (sent % 3 == 1) ? 17'h10040 : 17'h00040});
            sent++;
         end else begin
            bus_if.RX_AVST_VALID = 1'b0;
         end
         if (bus_if.TX_MFB_SRC_RDY && bus_if.TX_MFB_DST_RDY && sb.size() > 0) begin
            head = sb.pop_front();
            chk_d("t5_data", bus_if.TX_MFB_DATA, head.data);
            chk("t5_meta_flags", {8'd0, bus_if.TX_MFB_META, bus_if.TX_MFB_SOF, bus_if.TX_MFB_EOF,
                                  bus_if.TX_MFB_EOF_POS},
                {8'd0, head.meta, 1'b1, 1'b1, 6'd63});
            got++;
         end
         tick();
      end
      chk("t5_received", 32'(got), 32'd10);
      idle();
`ifdef AVST_RX_TO_MFB_STATS_EN
      chk("t5_stat_frames", stat_frames, 32'd13);
      chk("t5_stat_trunc", stat_trunc, 32'd2);
      chk("t5_stat_drop", stat_drop, 32'd1);
`endif

      // reset mid-frame with five words buffered
      bus_if.TX_MFB_DST_RDY = 1'b0;
      for (int k = 0; k < 5; k++) begin
         send(pat(8'(100 + k)), (k == 0), 1'b0, 6'd0, 6'd0);
      end
      chk("t6_buffered", 32'(bus_if.TX_MFB_SRC_RDY), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_async_clear", 32'(bus_if.TX_MFB_SRC_RDY), 32'd0);
      chk_d("t6_data_clear", bus_if.TX_MFB_DATA, '0);
      idle();
      rst_n = 1'b1;
      bus_if.TX_MFB_DST_RDY = 1'b1;
      send(pat(8'h22), 1'b0, 1'b0, 6'd0, 6'd0);
      chk("t6_mid_dropped", 32'(bus_if.TX_MFB_SRC_RDY), 32'd0);
      send(pat(8'h23), 1'b0, 1'b1, 6'd0, 6'd0);
      chk("t6_eop_dropped", 32'(bus_if.TX_MFB_SRC_RDY), 32'd0);
      send(pat(8'h24), 1'b1, 1'b1, 6'd0, 6'd0);
      chk("t6_new_flags", 32'({bus_if.TX_MFB_SOF, bus_if.TX_MFB_EOF}), 32'd3);
      chk("t6_new_meta", 32'(bus_if.TX_MFB_META), 32'd64);
      chk_d("t6_new_data", bus_if.TX_MFB_DATA, pat_mfb(8'h24));
      idle();
`ifdef AVST_RX_TO_MFB_STATS_EN
      chk("t6_stat_frames", stat_frames, 32'd1);
      chk("t6_stat_trunc", stat_trunc, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
